// File: rtl/hybrid_mult_pipe.sv
// hybrid_mult_pipe: 3-stage exact/approximate multiplier with valid/ready stall
// and a saturating counter of approximate results that differ from exact.
module hybrid_mult_pipe #(
   parameter int WIDTH = 8,
   parameter int K = 3,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               out_mode,
   output logic               mismatch,
   output logic [CNT_W-1:0]   mismatch_count,
   input  logic               clr_count
);
   localparam int P = 2 * WIDTH;
   localparam int H2 = 2 * (WIDTH - K);
   logic             advance, c0;
   logic             v1, m1, c1, v2, m2;
   logic [WIDTH-1:0] a1, b1, hl1, lh1;
   logic [K-1:0]     ll1;
   logic [H2-1:0]    hh1;
   logic [P-1:0]     ap2, ex2, ap_sum, ex_sum;
   assign advance = !out_valid | out_ready;
   assign in_ready = advance;
   // carry-out of the K-bit sum aL+bL compensates the OR approximation
   assign c0 = ((K+1)'(a[K-1:0]) + (K+1)'(b[K-1:0])) >= (K+1)'(1 << K);
   assign ap_sum = P'(ll1) + (P'(hl1) << K) + (P'(lh1) << K) + (P'(hh1) << (2*K)) + (P'(c1) << K);
   assign ex_sum = P'(a1) * P'(b1);
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         out_valid <= 1'b0;
         product <= '0;
         out_mode <= 1'b0;
         mismatch <= 1'b0;
      end else if (advance) begin
         v1 <= in_valid;
         m1 <= mode;
         a1 <= a;
         b1 <= b;
         c1 <= c0;
         ll1 <= a[K-1:0] | b[K-1:0];
         hl1 <= WIDTH'(a[WIDTH-1:K]) * WIDTH'(b[K-1:0]);
         lh1 <= WIDTH'(a[K-1:0]) * WIDTH'(b[WIDTH-1:K]);
         hh1 <= H2'(a[WIDTH-1:K]) * H2'(b[WIDTH-1:K]);
         v2 <= v1;
         m2 <= m1;
         ap2 <= ap_sum;
         ex2 <= ex_sum;
         out_valid <= v2;
         if (v2) begin
            product <= m2 ? ap2 : ex2;
            out_mode <= m2;
            mismatch <= m2 & (ap2 != ex2);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst || clr_count)
         mismatch_count <= '0;
      else if (out_valid && out_ready && mismatch && mismatch_count != '1)
         mismatch_count <= mismatch_count + 1'b1;
   end
endmodule

// File: tb/tb_hybrid_mult_pipe.sv
// tb_hybrid_mult_pipe: vector table plus scoreboard; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_hybrid_mult_pipe;
   localparam int W = 8;
   localparam int K = 3;
   typedef struct {logic [15:0] p; logic m; logic mm;} exp_t;
   typedef struct {logic [7:0] a; logic [7:0] b; logic m; logic [15:0] p; logic mm;} vec_t;
   logic clk = 0, rst = 1, in_valid = 0, mode = 0, out_ready = 1, clr_count = 0;
   logic [W-1:0] a = 0, b = 0;
   logic in_ready, out_valid, out_mode, mismatch;
   logic [2*W-1:0] product;
   logic [15:0] mismatch_count;
   logic in_ready2, out_valid2, out_mode2, mismatch2;
   logic [2*W-1:0] product2;
   logic [1:0] mismatch_count2;
   int checks = 0, errors = 0, run = 0, max_run = 0, delivered = 0;
   exp_t q[$];
   vec_t tbl[8];
   hybrid_mult_pipe #(.WIDTH(W), .K(K), .CNT_W(16)) dut (.clk(clk), .rst(rst), .in_valid(in_valid),
      .in_ready(in_ready), .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .out_mode(out_mode), .mismatch(mismatch), .mismatch_count(mismatch_count),
      .clr_count(clr_count));
   hybrid_mult_pipe #(.WIDTH(W), .K(K), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid),
      .in_ready(in_ready2), .a(a), .b(b), .mode(mode), .out_valid(out_valid2), .out_ready(out_ready),
      .product(product2), .out_mode(out_mode2), .mismatch(mismatch2), .mismatch_count(mismatch_count2),
      .clr_count(clr_count));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic logic [16:0] model(input logic [7:0] x, input logic [7:0] y, input logic md);
      logic [31:0] xl, xh, yl, yh, c, ap, ex;
      xl = 32'(x[K-1:0]);
      yl = 32'(y[K-1:0]);
      xh = 32'(x >> K);
      yh = 32'(y >> K);
      c = (xl + yl) >> K;
      ap = (xl | yl) + ((xh * yl) << K) + ((xl * yh) << K) + ((xh * yh) << (2*K)) + (c << K);
      ex = 32'(x) * 32'(y);
      return {md && (ap[15:0] != ex[15:0]), md ? ap[15:0] : ex[15:0]};
   endfunction
   // output transfers and acceptances are both decided by values stable at the negedge
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         run = 0;
      end else begin
         run = out_valid ? run + 1 : 0;
         if (run > max_run) max_run = run;
         if (out_valid && out_ready) begin
            delivered++;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got product %0d expected none", product);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("product", 32'(product), 32'(e.p));
               chk("out_mode", 32'(out_mode), 32'(e.m));
               chk("mismatch", 32'(mismatch), 32'(e.mm));
            end
         end
      end
   end
   task automatic send(input logic [7:0] ta, input logic [7:0] tv, input logic tm,
                       input logic [15:0] ep, input logic emm);
      bit ok = 0;
      a = ta;
      b = tv;
      mode = tm;
      in_valid = 1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back('{ep, tm, emm});
            ok = 1;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1");
      end
      @(posedge clk);
      #1 in_valid = 0;
   endtask
   task automatic send_m(input logic [7:0] ta, input logic [7:0] tv, input logic tm);
      logic [16:0] r;
      r = model(ta, tv, tm);
      send(ta, tv, tm, r[15:0], r[16]);
   endtask
   task automatic drain();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      chk("drain_left", 32'(q.size()), 0);
      @(posedge clk);
      #1;
   endtask
   initial begin
      int d0, exp_cnt;
      logic [15:0] hold;
      logic [16:0] r;
      tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'd65025, 1'b0};
      tbl[1] = '{8'h05, 8'h03, 1'b1, 16'd15, 1'b0};
      tbl[2] = '{8'h02, 8'h02, 1'b1, 16'd2, 1'b1};
      tbl[3] = '{8'h08, 8'h08, 1'b1, 16'd64, 1'b0};
      tbl[4] = '{8'h00, 8'hAB, 1'b1, 16'd3, 1'b1};
      tbl[5] = '{8'h07, 8'h01, 1'b1, 16'd15, 1'b1};
      tbl[6] = '{8'h10, 8'h0F, 1'b0, 16'd240, 1'b0};
      tbl[7] = '{8'hFF, 8'hFF, 1'b1, 16'd64991, 1'b1};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_product", 32'(product), 0);
      chk("rst_count", 32'(mismatch_count), 0);
      rst = 0;
      // latency: accepted at edge t, visible after edge t+2
      send(8'hFF, 8'hFF, 1'b1, 16'd64991, 1'b1);
      @(posedge clk);
      #1 chk("lat_not_yet", 32'(out_valid), 0);
      @(posedge clk);
      #1 chk("lat_valid", 32'(out_valid), 1);
      chk("lat_product", 32'(product), 64991);
      @(posedge clk);
      #1 chk("count_first", 32'(mismatch_count), 1);
      foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].p, tbl[i].mm);
      drain();
      chk("count_after_table", 32'(mismatch_count), 5);
      chk("count2_saturated", 32'(mismatch_count2), 3);
      max_run = 0;
      exp_cnt = 5;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         r = model(ra, rb, 1'(i % 2));
         exp_cnt += int'(r[16]);
         send(ra, rb, 1'(i % 2), r[15:0], r[16]);
      end
      drain();
      chk("stream_run", 32'(max_run), 8);
      chk("stream_count", 32'(mismatch_count), 32'(exp_cnt));
      chk("count2_holds", 32'(mismatch_count2), 3);
      out_ready = 0;
      d0 = delivered;
      send_m(8'h02, 8'h02, 1'b1);
      send_m(8'hC3, 8'h5A, 1'b0);
      send_m(8'h37, 8'h91, 1'b1);
      hold = product;
      for (int i = 0; i < 5; i++) begin
         chk("stall_in_ready", 32'(in_ready), 0);
         chk("stall_hold", 32'(product), 32'(hold));
         @(posedge clk);
         #1;
      end
      out_ready = 1;
      drain();
      chk("stall_delivered", 32'(delivered - d0), 3);
      send(8'h02, 8'h02, 1'b1, 16'd2, 1'b1);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      clr_count = 1;
      @(posedge clk);
      #1 clr_count = 0;
      chk("clr_wins", 32'(mismatch_count), 0);
      chk("clr_wins2", 32'(mismatch_count2), 0);
      send(8'h02, 8'h02, 1'b1, 16'd2, 1'b1);
      drain();
      chk("count_after_clr", 32'(mismatch_count), 1);
      send(8'h02, 8'h02, 1'b1, 16'd2, 1'b1);
      send(8'h05, 8'h03, 1'b1, 16'd15, 1'b0);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < 3; i++) begin
         chk("rst_flush_valid", 32'(out_valid), 0);
         @(posedge clk);
         #1;
      end
      chk("rst_flush_product", 32'(product), 0);
      chk("rst_flush_count", 32'(mismatch_count), 0);
      chk("final_queue", 32'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hybrid_mult_pipe.md
# hybrid_mult_pipe

Pipelined, parametrised hybrid multiplier with valid/ready handshaking. Each transaction selects exact or approximate mode. Approximate mode splits operands at bit K: an OR-approximated LSB×LSB term, exact cross and MSB products, and a carry-out compensation term. The block sits between operand producers and accumulators in the datapath, and keeps a saturating count of approximate results that differ from the exact product, for on-line error monitoring.

## Interface
- WIDTH, 8, operand width; legal range 4..16
- K, 3, LSB split point; legal range 1..WIDTH-1
- CNT_W, 16, width of the mismatch counter
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  block accepts a transaction this cycle
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned
- mode  in  1  0 = exact product, 1 = approximate product
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- product  out  2*WIDTH  selected product
- out_mode  out  1  mode of the transaction being presented
- mismatch  out  1  approximate result differs from exact (0 when out_mode=0)
- mismatch_count  out  CNT_W  saturating count of delivered mismatching results
- clr_count  in  1  synchronous clear of mismatch_count

## Operation
- Operand split: aH=a[WIDTH-1:K], aL=a[K-1:0]; bH and bL split the same way.
- Approximate product: (aL|bL) + ((aH*bL)<<K) + ((aL*bH)<<K) + ((aH*bH)<<2K) + (c<<K), where c is the carry-out of the K-bit sum aL+bL.
- Exact product: a*b.
- All sums are formed at full precision and truncated to 2*WIDTH bits, so any overflow wraps modulo 2^(2*WIDTH).
- Both products are always computed. product = approximate when mode=1, exact otherwise.
- mismatch = mode & (approx != exact).
- Pipeline has three register stages, each with a valid bit:
  - S1 registers a, b, mode, and the partial products.
  - S2 registers the approximate and exact sums.
  - S3 registers product, out_mode, mismatch, and out_valid.
- Global stall: advance = !out_valid | out_ready; in_ready = advance.
- While advance=0, every stage holds its contents. Bubbles are not squeezed out during a stall.
- Acceptance requires in_valid & in_ready at a rising edge. When in_valid=0 and advance=1, a bubble (valid=0) enters S1.
- While out_valid=1 and out_ready=0, product, out_mode, and mismatch hold stable.
- mismatch_count update, evaluated at each edge:
  - if rst or clr_count, it is set to 0; clear wins over a simultaneous increment;
  - else if out_valid & out_ready & mismatch, it increments and saturates at 2^CNT_W-1.

## Timing
- Reset values: in_ready=1 during reset, because out_valid is 0. out_valid, product, out_mode, mismatch, mismatch_count, and all stage valid bits reset to 0.
- Reset mid-operation discards all in-flight transactions. No result is ever presented for them.
- Latency: a transaction accepted at edge t is presented with out_valid=1 after edge t+2, i.e. 3 cycles, provided no stall occurs.
- Throughput: one transaction per cycle while out_ready=1.
- Stalls: each cycle with out_valid=1 and out_ready=0 adds exactly one cycle to the latency of every transaction in flight.
- in_ready is combinational from out_valid and out_ready. No other combinational input-to-output path exists.
- A simultaneous output transfer and input acceptance in the same cycle is legal, and the pipeline shifts by one stage.

## Test plan
- WIDTH=8, K=3, mode=1, a=0xFF, b=0xFF, out_ready=1 -> after 3 cycles: product=64991 (0xFDDF), mismatch=1, mismatch_count=1; the same operands with mode=0 -> product=65025, mismatch=0.
- mode=1, a=0x05, b=0x03 -> product=15, mismatch=0 (compensation exact); a=0x02, b=0x02 -> product=2, mismatch=1; a=0x08, b=0x08 -> product=64, mismatch=0.
- Back-to-back stream of 8 alternating-mode transactions with out_ready=1 -> 8 consecutive out_valid cycles, results in order, out_mode alternating.
- Hold out_ready=0 for 5 cycles with 3 transactions in flight -> in_ready=0 and output held stable; after release, all 3 results are delivered in order with none lost or duplicated.
- CNT_W=2, issue 5 mismatching transactions -> count reaches 3 and holds. Assert clr_count in the same cycle as a mismatching output transfer -> count=0.
- Assert rst for 1 cycle with 2 transactions in flight -> out_valid stays 0 for the next 3 cycles, mismatch_count=0, and product=0.
